// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared constants and FSM state type for the PE operand feeder
package pe_pkg;
   localparam int INPUT_NUM  = 7;
   localparam int WEIGHT_NUM = 3;
   localparam int DW_IN      = 8;
   localparam int ADDR_W     = 12;
   localparam int ROW_W      = 4;
   localparam int STEP       = INPUT_NUM - WEIGHT_NUM + 1;
   localparam int CNT_W      = $clog2(INPUT_NUM + 2);

   typedef enum logic [2:0] {
      IDLE,
      LD_WHT,
      LD_FMAP,
      OUT,
      FIN
   } feeder_state_t;
endpackage

// File: rtl/pe_feeder_if.sv
// rtl/pe_feeder_if.sv - operand bundle valid/ready channel from feeder to PE row
interface pe_feeder_if;
   import pe_pkg::*;

   logic [INPUT_NUM*DW_IN-1:0]  ifmap;
   logic [WEIGHT_NUM*DW_IN-1:0] iwht;
   logic                        o_valid;
   logic                        o_ready;
   logic [ROW_W-1:0]            o_row;
   logic [ADDR_W-1:0]           o_col;
   logic                        o_last;

   modport master (output ifmap, iwht, o_valid, o_row, o_col, o_last, input o_ready);
   modport slave  (input ifmap, iwht, o_valid, o_row, o_col, o_last, output o_ready);
endinterface

// File: rtl/pe_feeder.sv
// rtl/pe_feeder.sv - reads weights and padded pixel windows from the buffers and
// presents them as one bundle per handshake to the PE row
module pe_feeder
   import pe_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] fmap_base,
   input  logic [ADDR_W-1:0] wht_base,
   input  logic [ADDR_W-1:0] row_len,
   input  logic [ROW_W-1:0]  num_rows,
   output logic              busy,
   output logic              done,
   output logic              fm_rd_en,
   output logic [ADDR_W-1:0] fm_addr,
   input  logic [DW_IN-1:0]  fm_rdata,
   output logic              wt_rd_en,
   output logic [ADDR_W-1:0] wt_addr,
   input  logic [DW_IN-1:0]  wt_rdata,
   pe_feeder_if.master       pe
);
   feeder_state_t     state;
   logic [ADDR_W-1:0] len_q;
   logic [ROW_W-1:0]  rows_q;
   logic [ROW_W-1:0]  r;
   logic [ADDR_W-1:0] c;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  rd_idx;
   logic [CNT_W-1:0]  pend_idx;
   logic              fm_pend;
   logic              wt_pend;
   logic [ADDR_W-1:0] fm_row_base;
   logic [ADDR_W-1:0] wt_row_base;

   logic [ADDR_W:0]   pix;
   logic [ADDR_W:0]   c_step;
   logic [ROW_W:0]    r_next;

   assign pix    = {1'b0, c} + (ADDR_W+1)'(cnt);
   assign c_step = {1'b0, c} + (ADDR_W+1)'(STEP);
   assign r_next = {1'b0, r} + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         fm_rd_en    <= 1'b0;
         fm_addr     <= '0;
         wt_rd_en    <= 1'b0;
         wt_addr     <= '0;
         pe.ifmap    <= '0;
         pe.iwht     <= '0;
         pe.o_valid  <= 1'b0;
         pe.o_row    <= '0;
         pe.o_col    <= '0;
         pe.o_last   <= 1'b0;
         len_q       <= '0;
         rows_q      <= '0;
         r           <= '0;
         c           <= '0;
         cnt         <= '0;
         rd_idx      <= '0;
         pend_idx    <= '0;
         fm_pend     <= 1'b0;
         wt_pend     <= 1'b0;
         fm_row_base <= '0;
         wt_row_base <= '0;
      end else begin
         // Buffer data arrives one cycle after the strobe; capture it one edge later.
         fm_pend  <= fm_rd_en;
         wt_pend  <= wt_rd_en;
         pend_idx <= rd_idx;
         if (fm_pend)
            pe.ifmap[(INPUT_NUM-1-int'(pend_idx))*DW_IN +: DW_IN] <= fm_rdata;
         if (wt_pend)
            pe.iwht[(WEIGHT_NUM-1-int'(pend_idx))*DW_IN +: DW_IN] <= wt_rdata;

         case (state)
            IDLE: begin
               done <= 1'b0;
               busy <= 1'b0;
               if (start && !busy) begin
                  busy        <= 1'b1;
                  len_q       <= row_len;
                  rows_q      <= num_rows;
                  r           <= '0;
                  c           <= '0;
                  cnt         <= '0;
                  fm_row_base <= fmap_base;
                  wt_row_base <= wht_base;
                  state       <= (row_len == '0 || num_rows == '0) ? FIN : LD_WHT;
               end
            end
            LD_WHT: begin
               if (cnt < CNT_W'(WEIGHT_NUM)) begin
                  wt_rd_en <= 1'b1;
                  wt_addr  <= wt_row_base + ADDR_W'(cnt);
                  rd_idx   <= cnt;
                  cnt      <= cnt + 1'b1;
               end else begin
                  wt_rd_en <= 1'b0;
                  cnt      <= '0;
                  state    <= LD_FMAP;
               end
            end
            LD_FMAP: begin
               if (cnt < CNT_W'(INPUT_NUM)) begin
                  if (pix < {1'b0, len_q}) begin
                     fm_rd_en <= 1'b1;
                     fm_addr  <= fm_row_base + c + ADDR_W'(cnt);
                  end else begin
                     fm_rd_en <= 1'b0;
                     pe.ifmap[(INPUT_NUM-1-int'(cnt))*DW_IN +: DW_IN] <= '0;
                  end
                  rd_idx <= cnt;
                  cnt    <= cnt + 1'b1;
               end else begin
                  fm_rd_en <= 1'b0;
                  cnt      <= '0;
                  state    <= OUT;
               end
            end
            OUT: begin
               // First OUT cycle lets the final pixel capture land before valid rises.
               if (!pe.o_valid) begin
                  pe.o_valid <= 1'b1;
                  pe.o_row   <= r;
                  pe.o_col   <= c;
                  pe.o_last  <= (r == rows_q - 1'b1) && (c_step >= {1'b0, len_q});
               end else if (pe.o_ready) begin
                  pe.o_valid <= 1'b0;
                  if (c_step < {1'b0, len_q}) begin
                     c     <= c_step[ADDR_W-1:0];
                     state <= LD_FMAP;
                  end else begin
                     c           <= '0;
                     r           <= r_next[ROW_W-1:0];
                     fm_row_base <= fm_row_base + len_q;
                     wt_row_base <= wt_row_base + ADDR_W'(WEIGHT_NUM);
                     state       <= (r_next < {1'b0, rows_q}) ? LD_WHT : FIN;
                  end
               end
            end
            FIN: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pe_feeder.sv
// tb/tb_pe_feeder.sv - self-checking bench for pe_feeder against a window-list model
module tb_pe_feeder;
   import pe_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] fmap_base = '0, wht_base = '0, row_len = '0;
   logic [ROW_W-1:0]  num_rows = '0;
   logic              busy, done, fm_rd_en, wt_rd_en;
   logic [ADDR_W-1:0] fm_addr, wt_addr;
   logic [DW_IN-1:0]  fm_rdata, wt_rdata;

   pe_feeder_if pe();

   pe_feeder dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .fmap_base(fmap_base), .wht_base(wht_base), .row_len(row_len), .num_rows(num_rows),
      .busy(busy), .done(done),
      .fm_rd_en(fm_rd_en), .fm_addr(fm_addr), .fm_rdata(fm_rdata),
      .wt_rd_en(wt_rd_en), .wt_addr(wt_addr), .wt_rdata(wt_rdata),
      .pe(pe)
   );

   always #5 clk = ~clk;

   logic [7:0] fmem [4096];
   logic [7:0] wmem [4096];

   always @(posedge clk) begin
      if (fm_rd_en) fm_rdata <= fmem[fm_addr];
      if (wt_rd_en) wt_rdata <= wmem[wt_addr];
   end

   typedef struct {
      logic [INPUT_NUM*DW_IN-1:0]  ifm;
      logic [WEIGHT_NUM*DW_IN-1:0] iw;
      int row;
      int col;
      bit last;
      int nrd;
   } bundle_t;

   bundle_t exp_q[$];
   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected bundle list straight from the window/padding rules.
   function automatic void build(input int fb, input int wb, input int len, input int rows);
      bundle_t b;
      exp_q.delete();
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < len; c += STEP) begin
            b.row = r;
            b.col = c;
            b.last = (r == rows - 1) && (c + STEP >= len);
            b.nrd = 0;
            for (int i = 0; i < INPUT_NUM; i++) begin
               if (c + i < len) begin
                  b.ifm[(INPUT_NUM-1-i)*DW_IN +: DW_IN] = fmem[(fb + r*len + c + i) & 'hFFF];
                  b.nrd++;
               end else begin
                  b.ifm[(INPUT_NUM-1-i)*DW_IN +: DW_IN] = '0;
               end
            end
            for (int k = 0; k < WEIGHT_NUM; k++)
               b.iw[(WEIGHT_NUM-1-k)*DW_IN +: DW_IN] = wmem[(wb + WEIGHT_NUM*r + k) & 'hFFF];
            exp_q.push_back(b);
         end
      end
   endfunction

   task automatic chk_bundle(input string tag);
      chk({tag, "_ifmap"}, pe.ifmap, exp_q[0].ifm);
      chk({tag, "_iwht"}, pe.iwht, exp_q[0].iw);
      chk({tag, "_row_col_last"}, {pe.o_row, pe.o_col, pe.o_last},
          {exp_q[0].row[ROW_W-1:0], exp_q[0].col[ADDR_W-1:0], exp_q[0].last});
   endtask

   task automatic run_job(input int fb, input int wb, input int len, input int rows,
                          input int rdy_pct, input bit extra_start);
      int cyc = 0, last_hs = 0, final_hs = -1, done_cyc = -1, ndone = 0;
      int rd_f = 0, rd_f_win = 0, rd_w = 0, exp_rd_f = 0;
      bit in_bundle = 1'b0, had_bundles, rdy;
      build(fb, wb, len, rows);
      had_bundles = (exp_q.size() != 0);
      foreach (exp_q[j]) exp_rd_f += exp_q[j].nrd;
      @(negedge clk);
      fmap_base = fb[ADDR_W-1:0];
      wht_base  = wb[ADDR_W-1:0];
      row_len   = len[ADDR_W-1:0];
      num_rows  = rows[ROW_W-1:0];
      start     = 1'b1;
      while (cyc < 3000) begin
         @(negedge clk);
         cyc++;
         start = extra_start && (cyc == 20);
         if (cyc == 1) begin
            fmap_base = ADDR_W'($urandom);
            wht_base  = ADDR_W'($urandom);
            row_len   = ADDR_W'($urandom);
            num_rows  = ROW_W'($urandom);
            chk("busy_after_start", busy, 1'b1);
         end
         if (fm_rd_en) begin rd_f++; rd_f_win++; end
         if (wt_rd_en) rd_w++;
         if (done) begin
            ndone++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (pe.o_valid) begin
            if (exp_q.size() == 0) begin
               chk("extra_bundle", exp_q.size(), 1);
               pe.o_ready = 1'b1;
            end else begin
               if (!in_bundle) begin
                  in_bundle = 1'b1;
                  chk("valid_latency", cyc - 1 - last_hs, (exp_q[0].col == 0) ? 13 : 9);
                  chk("window_reads", rd_f_win, exp_q[0].nrd);
                  chk_bundle("bundle");
               end else begin
                  chk_bundle("held");
                  chk("held_no_strobes", {fm_rd_en, wt_rd_en}, 2'b00);
               end
               rdy = ($urandom_range(99) < rdy_pct);
               pe.o_ready = rdy;
               if (rdy) begin
                  last_hs = cyc;
                  in_bundle = 1'b0;
                  rd_f_win = 0;
                  void'(exp_q.pop_front());
                  if (exp_q.size() == 0) final_hs = cyc;
               end
            end
         end else begin
            pe.o_ready = 1'($urandom_range(1));
         end
         if (done_cyc >= 0 && cyc > done_cyc + 2) break;
      end
      chk("job_ended", done_cyc >= 0, 1'b1);
      chk("bundles_left", exp_q.size(), 0);
      chk("done_count", ndone, 1);
      chk("done_time", done_cyc, had_bundles ? final_hs + 2 : 2);
      chk("busy_after_done", busy, 1'b0);
      chk("fm_reads_total", rd_f, exp_rd_f);
      chk("wt_reads_total", rd_w, (len == 0 || rows == 0) ? 0 : WEIGHT_NUM * rows);
      pe.o_ready = 1'b0;
   endtask

   initial begin
      int seen, dcount;
      pe.o_ready = 1'b0;
      for (int a = 0; a < 4096; a++) begin
         fmem[a] = a[7:0];
         wmem[a] = 8'h80 | a[7:0];
      end
      repeat (2) @(negedge clk);
      chk("reset_ctrl", {busy, done, fm_rd_en, wt_rd_en, fm_addr, wt_addr,
                         pe.o_valid, pe.o_row, pe.o_col, pe.o_last}, '0);
      chk("reset_data", {pe.ifmap, pe.iwht}, '0);
      rst_n = 1'b1;

      run_job(0, 'h100, 10, 3, 100, 1'b1);
      run_job(0, 'h100, 7, 1, 100, 1'b0);
      run_job(40, 'h200, 12, 2, 30, 1'b0);
      run_job(0, 0, 0, 3, 100, 1'b0);
      run_job(0, 0, 5, 0, 100, 1'b0);

      // Asynchronous reset while a bundle is waiting for ready.
      @(negedge clk);
      fmap_base = '0; wht_base = 'h100; row_len = 10; num_rows = 2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 0;
      for (int i = 0; i < 40 && seen == 0; i++) begin
         @(negedge clk);
         if (pe.o_valid) seen = 1;
      end
      chk("reset_test_valid_seen", seen, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midjob_reset_ctrl", {busy, done, fm_rd_en, wt_rd_en, fm_addr, wt_addr,
                                pe.o_valid, pe.o_row, pe.o_col, pe.o_last}, '0);
      chk("midjob_reset_data", {pe.ifmap, pe.iwht}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      dcount = 0;
      repeat (6) begin
         @(negedge clk);
         if (done || busy || pe.o_valid) dcount++;
      end
      chk("idle_after_reset", dcount, 0);
      run_job(0, 'h100, 10, 2, 100, 1'b0);

      for (int t = 0; t < 4; t++) begin
         for (int a = 0; a < 4096; a++) begin
            fmem[a] = 8'($urandom);
            wmem[a] = 8'($urandom);
         end
         run_job($urandom_range(4095), $urandom_range(4095), $urandom_range(20, 1),
                 $urandom_range(4, 1), 60, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
